// File: rtl/audio_stream_fifo_pkg.sv
// Shared types and default constants for the audio stream FIFO.
// Read FSM state encoding plus CD-audio default sizing.
package audio_stream_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    PLAY,
    FETCH
  } state_t;

  localparam int CD_SECTOR_WORDS   = 1176;
  localparam int CD_FRAME_CHANNELS = 2;

endpackage

// File: rtl/audio_stream_fifo_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Read data appears one cycle after the address is presented.
module audio_stream_fifo_ram
  import audio_stream_fifo_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk_sys,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/audio_stream_fifo.sv
// Multi-channel audio sample FIFO between the disk stream and the mixer.
// Optional per-frame attenuation when AUDIO_STREAM_FIFO_ATTEN_EN is defined.
module audio_stream_fifo
  import audio_stream_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH  = 12,
  parameter int DW          = 16,
  parameter int CHANNELS    = CD_FRAME_CHANNELS,
  parameter int REQ_BLOCK   = CD_SECTOR_WORDS,
  parameter int START_LEVEL = CD_SECTOR_WORDS,
  parameter int SWAP_BYTES  = 1
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   cen_sample,
  input  logic                   flush,
  output logic                   stream_req,
  input  logic                   stream_wr,
  input  logic [DW-1:0]          stream_data,
  output logic [CHANNELS*DW-1:0] samples,
  output logic                   sample_valid,
  output logic                   playing,
  output logic                   underrun,
  output logic                   overflow
`ifdef AUDIO_STREAM_FIFO_ATTEN_EN
  ,
  input  logic [3:0]             atten
`endif
);

  localparam int          PW       = FIFO_DEPTH + 1;
  localparam logic [31:0] DEPTH_W  = 32'(1) << FIFO_DEPTH;
  localparam logic [31:0] REQ_W    = 32'(REQ_BLOCK);
  localparam logic [31:0] START_W  = 32'(START_LEVEL);
  localparam logic [31:0] CH_W     = 32'(CHANNELS);
  localparam logic [2:0]  LAST_CNT = 3'(CHANNELS - 1);

  function automatic logic [DW-1:0] swap_bytes(input logic [DW-1:0] w);
    logic [DW-1:0] r;
    r = '0;
    for (int b = 0; b < DW / 8; b++) r[b*8 +: 8] = w[DW-8-b*8 +: 8];
    return r;
  endfunction

`ifdef AUDIO_STREAM_FIFO_ATTEN_EN
  function automatic logic [DW-1:0] atten_shift(input logic [DW-1:0] w, input logic [3:0] a);
    logic signed [DW-1:0] s;
    s = signed'(w);
    return DW'(s >>> a);
  endfunction
`endif

  state_t          state, state_nx;
  logic [PW-1:0]   wptr, rptr, used;
  logic [31:0]     used_w;
  logic            full, wr_en;
  logic [DW-1:0]   wr_data;
  logic [DW-1:0]   rd_data_p1;
  logic [2:0]      cnt;
  logic            pop, fetch_start, load, last, underrun_ev;
  logic [DW-1:0]   samples_q [CHANNELS];

  assign used       = wptr - rptr;
  assign used_w     = 32'(used);
  assign full       = (used_w == DEPTH_W);
  assign stream_req = (DEPTH_W - used_w) >= REQ_W;
  assign wr_en      = clk_en && stream_wr && !full && !flush && !reset;
  assign wr_data    = (SWAP_BYTES != 0) ? swap_bytes(stream_data) : stream_data;
  // FETCH is a sub-phase of playback, so playing stays high through it.
  assign playing    = (state == PLAY) || (state == FETCH);

  audio_stream_fifo_ram #(
    .AW (FIFO_DEPTH),
    .DW (DW)
  ) u_ram (
    .clk_sys (clk_sys),
    .wr_en   (wr_en),
    .wr_addr (wptr[FIFO_DEPTH-1:0]),
    .wr_data (wr_data),
    .rd_addr (rptr[FIFO_DEPTH-1:0]),
    .rd_data (rd_data_p1)
  );

  always_ff @(posedge clk_sys) begin
    if (reset || flush) state <= IDLE;
    else                state <= state_nx;
  end

  // The first pop is issued on the cen_sample cycle so channel 0 reaches
  // the output two cycles later despite the registered RAM read.
  always_comb begin
    state_nx    = state;
    pop         = 1'b0;
    fetch_start = 1'b0;
    load        = 1'b0;
    last        = 1'b0;
    underrun_ev = 1'b0;
    case (state)
      IDLE:  state_nx = PRIME;
      PRIME: if (cen_sample && used_w >= START_W) state_nx = PLAY;
      PLAY: begin
        if (cen_sample) begin
          if (used_w >= CH_W) begin
            fetch_start = 1'b1;
            pop         = 1'b1;
            state_nx    = FETCH;
          end else begin
            underrun_ev = 1'b1;
            state_nx    = PRIME;
          end
        end
      end
      FETCH: begin
        load = 1'b1;
        if (cnt == LAST_CNT) begin
          last     = 1'b1;
          state_nx = PLAY;
        end else begin
          pop = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset || flush) begin
      wptr         <= '0;
      rptr         <= '0;
      cnt          <= '0;
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      if (fetch_start) cnt <= '0;
      else if (load)   cnt <= cnt + 3'd1;
      sample_valid <= last;
      if (underrun_ev) underrun <= 1'b1;
      if (clk_en && stream_wr && full) overflow <= 1'b1;
    end
  end

`ifdef AUDIO_STREAM_FIFO_ATTEN_EN
  logic [3:0] atten_q;

  always_ff @(posedge clk_sys) begin
    if (fetch_start) atten_q <= atten;
  end
`endif

  // Output slots: each channel loads on its own FETCH cycle.
  always_ff @(posedge clk_sys) begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (reset || flush || underrun_ev) begin
        samples_q[k] <= '0;
      end else if (load && cnt == 3'(k)) begin
`ifdef AUDIO_STREAM_FIFO_ATTEN_EN
        samples_q[k] <= atten_shift(rd_data_p1, atten_q);
`else
        samples_q[k] <= rd_data_p1;
`endif
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
    assign samples[k*DW +: DW] = samples_q[k];
  end

endmodule

// File: tb/tb_audio_stream_fifo.sv
// Directed bench for audio_stream_fifo: a CD-default instance and a small
// 4-channel instance; attenuation vectors run when AUDIO_STREAM_FIFO_ATTEN_EN is set.
module tb_audio_stream_fifo;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset, clk_en;
  logic        cen_a, flush_a, wr_a, req_a, sv_a, playing_a, ur_a, ov_a;
  logic [15:0] data_a;
  logic [31:0] samples_a;
  logic        cen_b, flush_b, wr_b, req_b, sv_b, playing_b, ur_b, ov_b;
  logic [15:0] data_b;
  logic [63:0] samples_b;
`ifdef AUDIO_STREAM_FIFO_ATTEN_EN
  logic [3:0]  atten_a, atten_b;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  audio_stream_fifo u_dut_a (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .clk_en       (clk_en),
    .cen_sample   (cen_a),
    .flush        (flush_a),
    .stream_req   (req_a),
    .stream_wr    (wr_a),
    .stream_data  (data_a),
    .samples      (samples_a),
    .sample_valid (sv_a),
    .playing      (playing_a),
    .underrun     (ur_a),
    .overflow     (ov_a)
`ifdef AUDIO_STREAM_FIFO_ATTEN_EN
    ,
    .atten        (atten_a)
`endif
  );

  audio_stream_fifo #(
    .FIFO_DEPTH  (5),
    .DW          (16),
    .CHANNELS    (4),
    .REQ_BLOCK   (16),
    .START_LEVEL (8),
    .SWAP_BYTES  (0)
  ) u_dut_b (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .clk_en       (clk_en),
    .cen_sample   (cen_b),
    .flush        (flush_b),
    .stream_req   (req_b),
    .stream_wr    (wr_b),
    .stream_data  (data_b),
    .samples      (samples_b),
    .sample_valid (sv_b),
    .playing      (playing_b),
    .underrun     (ur_b),
    .overflow     (ov_b)
`ifdef AUDIO_STREAM_FIFO_ATTEN_EN
    ,
    .atten        (atten_b)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [15:0] bswap(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

  function automatic logic [15:0] word_a(input int i);
    if (i == 0) return 16'h1234;
    if (i == 1) return 16'h5678;
    return 16'(i);
  endfunction

  function automatic logic [15:0] word_b(input int i);
    return 16'(i * 311 + 17);
  endfunction

  task automatic write_a(input int first, input int n);
    for (int k = 0; k < n; k++) begin
      wr_a   = 1'b1;
      data_a = word_a(first + k);
      tick();
    end
    wr_a = 1'b0;
  endtask

  // One frame on instance A with a 5-cycle cen_sample period; s/v captured at t+3.
  task automatic frame_a(output logic [31:0] s, output logic v);
    cen_a = 1'b1;
    tick();
    cen_a = 1'b0;
    tick();
    tick();
    s = samples_a;
    v = sv_a;
    tick();
    tick();
  endtask

  task automatic prime_a();
    cen_a = 1'b1;
    tick();
    cen_a = 1'b0;
  endtask

  logic [15:0] q[$];
  logic [31:0] s;
  logic        v;
  logic [63:0] exp64;
  int          kb;

  initial begin
    reset = 1'b1; clk_en = 1'b1;
    cen_a = 1'b0; flush_a = 1'b0; wr_a = 1'b0; data_a = '0;
    cen_b = 1'b0; flush_b = 1'b0; wr_b = 1'b0; data_b = '0;
`ifdef AUDIO_STREAM_FIFO_ATTEN_EN
    atten_a = 4'd0; atten_b = 4'd0;
`endif
    tick();
    tick();
    reset = 1'b0;

    check("rst_req_a",     64'(req_a),     64'd1);
    check("rst_samples_a", 64'(samples_a), 64'd0);
    check("rst_valid_a",   64'(sv_a),      64'd0);
    check("rst_playing_a", 64'(playing_a), 64'd0);
    check("rst_flags_a",   64'({ur_a, ov_a}), 64'd0);
    check("rst_req_b",     64'(req_b),     64'd1);
    tick();

    // Prime with one CD sector and pull the first frame.
    write_a(0, 1176);
    check("prime_not_playing", 64'(playing_a), 64'd0);
    prime_a();
    check("prime_playing", 64'(playing_a), 64'd1);
    tick();
    cen_a = 1'b1;
    tick();
    cen_a = 1'b0;
    check("frame0_sv_t1", 64'(sv_a), 64'd0);
    tick();
    check("frame0_ch0_t2", 64'(samples_a[15:0]), 64'h3412);
    check("frame0_sv_t2", 64'(sv_a), 64'd0);
    tick();
    check("frame0_samples", 64'(samples_a), 64'h7856_3412);
    check("frame0_sv_t3", 64'(sv_a), 64'd1);
    check("frame0_playing", 64'(playing_a), 64'd1);
    tick();
    check("frame0_sv_t4", 64'(sv_a), 64'd0);
    tick();

    // Fill to capacity, then one dropped write.
    write_a(1176, 2922);
    check("full_req", 64'(req_a), 64'd0);
    check("full_no_ovf", 64'(ov_a), 64'd0);
    wr_a = 1'b1; data_a = 16'hDEAD;
    tick();
    wr_a = 1'b0;
    check("full_ovf", 64'(ov_a), 64'd1);
    check("full_req_after", 64'(req_a), 64'd0);
    for (int f = 0; f < 587; f++) frame_a(s, v);
    check("pop1174_req", 64'(req_a), 64'd0);
    frame_a(s, v);
    check("pop1176_req", 64'(req_a), 64'd1);
    check("pop1176_samples", 64'(s), 64'({bswap(word_a(1177)), bswap(word_a(1176))}));
    check("pop1176_sv", 64'(v), 64'd1);
    check("ovf_sticky", 64'(ov_a), 64'd1);

    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    check("flush_a_flags", 64'({ur_a, ov_a, playing_a}), 64'd0);
    check("flush_a_samples", 64'(samples_a), 64'd0);
    check("flush_a_req", 64'(req_a), 64'd1);
    tick();

    // Underrun: one word left when cen_sample arrives.
    write_a(0, 1177);
    prime_a();
    tick();
    for (int f = 0; f < 588; f++) frame_a(s, v);
    check("last_full_frame", 64'(s), 64'({bswap(word_a(1175)), bswap(word_a(1174))}));
    check("last_full_frame_sv", 64'(v), 64'd1);
    cen_a = 1'b1;
    tick();
    cen_a = 1'b0;
    check("ur_flag", 64'(ur_a), 64'd1);
    check("ur_playing", 64'(playing_a), 64'd0);
    check("ur_samples", 64'(samples_a), 64'd0);
    check("ur_sv_t1", 64'(sv_a), 64'd0);
    tick();
    check("ur_sv_t2", 64'(sv_a), 64'd0);
    tick();
    check("ur_sv_t3", 64'(sv_a), 64'd0);

    // Flush in the middle of a 4-channel fetch.
    for (int k = 0; k < 24; k++) begin
      wr_b = 1'b1; data_b = 16'h0100 + 16'(k);
      tick();
    end
    wr_b = 1'b0;
    check("b_req_low", 64'(req_b), 64'd0);
    cen_b = 1'b1;
    tick();
    cen_b = 1'b0;
    check("b_playing", 64'(playing_b), 64'd1);
    tick();
    cen_b = 1'b1;
    tick();
    cen_b = 1'b0;
    tick();
    check("b_ch0_before_flush", 64'(samples_b[15:0]), 64'h0100);
    flush_b = 1'b1;
    tick();
    flush_b = 1'b0;
    check("b_flush_samples", samples_b, 64'd0);
    check("b_flush_sv", 64'(sv_b), 64'd0);
    check("b_flush_req", 64'(req_b), 64'd1);
    check("b_flush_playing", 64'(playing_b), 64'd0);
    tick();
    check("b_flush_sv_t1", 64'(sv_b), 64'd0);
    tick();
    check("b_flush_sv_t2", 64'(sv_b), 64'd0);

    // Continuous playback across several pointer wraps.
    kb = 0;
    for (int k = 0; k < 8; k++) begin
      wr_b = 1'b1; data_b = word_b(kb); q.push_back(word_b(kb)); kb++;
      tick();
    end
    wr_b = 1'b0;
    cen_b = 1'b1;
    tick();
    cen_b = 1'b0;
    tick();
    for (int f = 0; f < 30; f++) begin
      for (int c = 0; c < 7; c++) begin
        cen_b = (c == 0);
        wr_b  = (c < 4);
        if (c < 4) begin
          data_b = word_b(kb); q.push_back(word_b(kb)); kb++;
        end
        tick();
        if (c == 4) begin
          exp64 = {q[3], q[2], q[1], q[0]};
          check($sformatf("wrap_frame%0d", f), samples_b, exp64);
          check($sformatf("wrap_sv%0d", f), 64'(sv_b), 64'd1);
          for (int p = 0; p < 4; p++) void'(q.pop_front());
        end
      end
    end
    cen_b = 1'b0; wr_b = 1'b0;
    check("wrap_flags", 64'({ur_b, ov_b}), 64'd0);

`ifdef AUDIO_STREAM_FIFO_ATTEN_EN
    flush_b = 1'b1;
    tick();
    flush_b = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) begin
      wr_b = 1'b1;
      case (k)
        0: data_b = 16'h8000;
        1: data_b = 16'h4000;
        2: data_b = 16'h7FFF;
        3: data_b = 16'hFFF0;
        default: data_b = 16'h0123;
      endcase
      tick();
    end
    wr_b = 1'b0;
    cen_b = 1'b1;
    tick();
    cen_b = 1'b0;
    tick();
    atten_b = 4'd2;
    cen_b = 1'b1;
    tick();
    cen_b = 1'b0;
    atten_b = 4'd0;
    for (int c = 0; c < 4; c++) tick();
    check("atten_samples", samples_b, 64'hFFFC_1FFF_1000_E000);
    check("atten_sv", 64'(sv_b), 64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/audio_stream_fifo.md
Name: audio_stream_fifo

Overview:
Parametrised multi-channel audio sample FIFO between the data_io disk-stream interface and the audio mixer. Next generation of the CDDA FIFO, with these generalisations:
- configurable sample width, depth, channel count and start threshold
- full/empty-exact pointers, flush control, underrun/overflow reporting
- a per-frame valid strobe

Parameters:
FIFO_DEPTH, 12, log2 of FIFO capacity in words.
DW, 16, sample/word width in bits; must be a multiple of 8.
CHANNELS, 2, interleaved channels per frame (1..8); word order ch0 first.
REQ_BLOCK, 1176, free words required before stream_req asserts (one 2352-byte CD sector).
START_LEVEL, 1176, fill level (words) required to leave PRIME.
SWAP_BYTES, 1, 1 = reverse byte order of each incoming word.

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high
clk_en  in  1  write-side clock enable; tie 1 with stock data_io
cen_sample  in  1  frame-rate enable (e.g. 44100 Hz); one-cycle pulse
flush  in  1  synchronous stream flush (track change / seek)
stream_req  out  1  request for another REQ_BLOCK of data
stream_wr  in  1  write strobe, qualified by clk_en
stream_data  in  DW  write word
samples  out  CHANNELS*DW  current frame; channel k at [k*DW +: DW]
sample_valid  out  1  one-cycle pulse when a new frame is complete in samples
playing  out  1  high in PLAY state
underrun  out  1  sticky; cleared by reset/flush
overflow  out  1  sticky; cleared by reset/flush

Behaviour:
- Pointers are FIFO_DEPTH+1 bits wide; used = wptr - rptr, modulo 2^(FIFO_DEPTH+1).
  - full: used == 2^FIFO_DEPTH
  - empty: used == 0
- stream_req = (2^FIFO_DEPTH - used) >= REQ_BLOCK. Combinational from registered pointers.
- Write: on clk_en & stream_wr & !full, store the word (byte-swapped if SWAP_BYTES) and increment wptr.
  - When full, the word is dropped, wptr is held and overflow is set.
- RAM is simple dual-port with registered read: data is available one cycle after the address.
- Read FSM states:
  - IDLE: outputs zero. Goes to PRIME on the next cycle.
  - PRIME: outputs zero, playing = 0. Goes to PLAY on the cen_sample cycle where used >= START_LEVEL.
  - PLAY: on cen_sample:
    - if used >= CHANNELS, go to FETCH;
    - otherwise set underrun, zero samples, go to PRIME. This covers the partial-frame case.
  - FETCH: pops CHANNELS words, one per cycle, on consecutive cycles.
    - If cen_sample arrives at cycle t, channel k is written into samples at cycle t+2+k.
    - sample_valid pulses at cycle t+1+CHANNELS (same cycle the last channel is written), then the FSM returns to PLAY.
- Channel slots in samples update individually during FETCH. Consumers must sample on sample_valid.
- The cen_sample period must exceed CHANNELS+2 cycles. A cen_sample arriving during FETCH is ignored.
- Simultaneous write and pop in one cycle: both pointers advance; used is unchanged net.
- flush and reset both:
  - rptr = wptr = 0
  - samples = 0; sample_valid, playing, underrun, overflow = 0
  - FSM = IDLE
  - Any in-flight FETCH is aborted. A write coinciding with flush is discarded.
  - reset takes priority over flush; both are identical in effect.
- Pointer wrap is natural binary rollover. The 2^(FIFO_DEPTH+1) boundary needs no special case.

Optional Feature:
Macro AUDIO_STREAM_FIFO_ATTEN_EN.
- Defined:
  - adds input atten [3:0];
  - each word loaded into samples is arithmetic-right-shifted by atten (signed two's-complement);
  - atten is sampled once at cen_sample and held for the whole frame;
  - latency is unchanged.
- Undefined: the port is absent and samples are raw FIFO words.

Decomposition:
- Package audio_stream_fifo_pkg holds:
  - the FSM state enum (IDLE, PRIME, PLAY, FETCH);
  - the default constants CD_SECTOR_WORDS = 1176 and CD_FRAME_CHANNELS = 2.
- One sub-module, audio_stream_fifo_ram: simple dual-port RAM, 2^FIFO_DEPTH x DW, one write port, registered read port.

Test Plan:
- Write 1176 words 0x1234, 0x5678, … (SWAP_BYTES=1, CHANNELS=2) → first frame after cen_sample: samples = {0x7856, 0x3412}; sample_valid at t+3; playing = 1.
- Fill to 4096 words → full; one extra write → dropped, overflow = 1, stream_req = 0. Pop 1176 words → stream_req = 1.
- Prime, then stop writing until used = 1 → next cen_sample: underrun = 1, samples = 0, FSM = PRIME, no sample_valid.
- Assert flush mid-FETCH (CHANNELS=4) → the following cycle: used = 0, samples = 0, sample_valid never pulses, stream_req = 1.
- Run writes across pointer wrap (≥ 3 × 4096 words) with continuous playback → output sequence matches input, no underrun/overflow.
- ATTEN_EN, atten = 2, word 0x8000 → sample 0xE000; atten changed mid-frame → frame still uses 2.
